// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Clears the buffers after reset, then handles load-use hazards, control
// redirects and data-memory wait states with a timeout.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   id_rs, id_rt     source fields of the instruction in ID
//   id_usesRt        ID instruction reads rt
//   ex_memRead       EX instruction is a load
//   ex_rt            load destination register in EX
//   ex_branchTaken   EX resolved a taken branch
//   ex_jump          EX instruction is a jump
//   mem_req          MEM instruction accesses data memory
//   mem_ready        data memory completes this cycle
//   pc_en, *_en      buffer load enables
//   *_flush          buffer loads a bubble (overrides enable)
//   state            INIT=0, RUN=1, MEM_WAIT=2, ERROR=3
//   err              sticky memory-timeout flag
//   stall_cnt        saturating count of cycles with the PC held
module pipeline_ctrl #(
    parameter int INIT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_usesRt,
    input  logic                   ex_memRead,
    input  logic [4:0]             ex_rt,
    input  logic                   ex_branchTaken,
    input  logic                   ex_jump,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   ifid_flush,
    output logic                   idex_en,
    output logic                   idex_flush,
    output logic                   exmem_en,
    output logic                   exmem_flush,
    output logic                   memwb_flush,
    output logic [1:0]             state,
    output logic                   err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERROR    = 2'd3
    } state_t;

    state_t            cur;
    logic [INIT_W-1:0] init_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic mem_stall;
    logic redirect;
    logic load_use;
    logic active;

    assign mem_stall = mem_req & ~mem_ready;
    assign redirect  = ex_branchTaken | ex_jump;
    // A load into r0 never produces a value worth waiting for.
    assign load_use  = ex_memRead && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (id_usesRt && (ex_rt == id_rt)));
    assign active    = (cur == S_RUN) || (cur == S_MEM_WAIT);
    assign state     = cur;

    // Mealy buffer control: RUN and a MEM_WAIT release share the same rules,
    // so a branch held in EX during a wait is acted on in the release cycle.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        unique case (cur)
            S_INIT: begin
                ifid_en     = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                memwb_flush = 1'b1;
            end
            S_RUN, S_MEM_WAIT: begin
                if (mem_stall) begin
                    memwb_flush = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    if (redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            end
            S_ERROR: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= S_INIT;
            init_cnt  <= '0;
            wait_cnt  <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (active && !pc_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            unique case (cur)
                S_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        init_cnt <= '0;
                        cur      <= S_RUN;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (mem_stall) begin
                        wait_cnt <= WAIT_W'(1);
                        cur      <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_stall) begin
                        // The RUN cycle that entered the wait already counts.
                        if (wait_cnt == WAIT_LAST) begin
                            cur <= S_ERROR;
                            err <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                        cur      <= S_RUN;
                    end
                end
                S_ERROR: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized self-checking bench for pipeline_ctrl against a
// behavioural model of the sequencing rules.
module tb_pipeline_ctrl;

    localparam int IC   = 2;
    localparam int MT   = 4;
    localparam int SW   = 5;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    id_rs = '0;
    logic [4:0]    id_rt = '0;
    logic          id_usesRt = 1'b0;
    logic          ex_memRead = 1'b0;
    logic [4:0]    ex_rt = '0;
    logic          ex_branchTaken = 1'b0;
    logic          ex_jump = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic          exmem_en, exmem_flush, memwb_flush;
    logic [1:0]    state;
    logic          err;
    logic [SW-1:0] stall_cnt;

    pipeline_ctrl #(
        .INIT_CYCLES(IC),
        .MEM_TIMEOUT(MT),
        .STALL_CNT_W(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_usesRt(id_usesRt),
        .ex_memRead(ex_memRead), .ex_rt(ex_rt),
        .ex_branchTaken(ex_branchTaken), .ex_jump(ex_jump),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_flush(memwb_flush),
        .state(state), .err(err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: mode 0..3, edges spent in INIT, consecutive stalled memory
    // cycles, sticky error, saturating stall count.
    int m_st, m_init, m_memst, m_err, m_stall;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
    //  exmem_en, exmem_flush, memwb_flush}
    function automatic logic [7:0] exp_ctl();
        logic ms, br, lu;
        ms = mem_req && !mem_ready;
        br = ex_branchTaken || ex_jump;
        lu = ex_memRead && ex_rt != 0 &&
             (ex_rt == id_rs || (id_usesRt && ex_rt == id_rt));
        if (m_st == 0) return 8'b0111_1111;
        if (m_st == 3) return 8'b0000_0000;
        if (ms)        return 8'b0000_0001;
        if (br)        return 8'b1111_1100;
        if (lu)        return 8'b0001_1100;
        return 8'b1101_0100;
    endfunction

    function automatic logic [7:0] obs_ctl();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                exmem_en, exmem_flush, memwb_flush};
    endfunction

    // Called at posedge+1: check mid-cycle, advance one edge.
    task automatic cyc();
        logic [7:0] e;
        logic ms;
        #4;
        e  = exp_ctl();
        ms = mem_req && !mem_ready;
        chk("ctl", 32'(obs_ctl()), 32'(e));
        chk("state", 32'(state), 32'(m_st));
        chk("err", 32'(err), 32'(m_err));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        @(posedge clk);
        if (!rst) begin
            case (m_st)
                0: begin
                    m_init++;
                    if (m_init == IC) begin
                        m_st = 1;
                        m_init = 0;
                    end
                end
                1, 2: begin
                    if (!e[7] && m_stall < SMAX) m_stall++;
                    if (ms) begin
                        m_memst++;
                        if (m_memst == MT) begin
                            m_st = 3;
                            m_err = 1;
                        end else begin
                            m_st = 2;
                        end
                    end else begin
                        m_st = 1;
                        m_memst = 0;
                    end
                end
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic clr_in();
        id_rs = '0; id_rt = '0; id_usesRt = 1'b0;
        ex_memRead = 1'b0; ex_rt = '0;
        ex_branchTaken = 1'b0; ex_jump = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Reset is raised mid-cycle; state must clear with no clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_async_state", 32'(state), 32'd0);
        chk("rst_async_err", 32'(err), 32'd0);
        chk("rst_async_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_async_ctl", 32'(obs_ctl()), 32'h7f);
        m_st = 0; m_init = 0; m_memst = 0; m_err = 0; m_stall = 0;
        #3;
        @(posedge clk);
        #1;
        cyc();
        rst = 1'b0;
    endtask

    logic slow_mem;

    initial begin
        clr_in();
        @(posedge clk);
        #1;
        do_reset();

        // INIT for two edges, then RUN with defaults.
        repeat (3) cyc();
        chk("run_after_init", 32'(state), 32'd1);

        // Load-use hit, then the bubble clears it.
        ex_memRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        cyc();
        ex_memRead = 1'b0;
        cyc();
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // Load into r0 never stalls.
        ex_memRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        cyc();
        // rt-only dependence, with and without usesRt.
        ex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_usesRt = 1'b0;
        cyc();
        id_usesRt = 1'b1;
        cyc();

        // Branch beats load-use.
        ex_branchTaken = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        cyc();
        ex_branchTaken = 1'b0; ex_jump = 1'b1; ex_memRead = 1'b0;
        cyc();
        clr_in();

        // Three wait cycles then release.
        mem_req = 1'b1;
        repeat (3) cyc();
        mem_ready = 1'b1;
        cyc();
        chk("mw_release_cnt", 32'(stall_cnt), 32'd5);

        // Branch held through a wait: flush only at release.
        mem_ready = 1'b0; ex_branchTaken = 1'b1;
        repeat (2) cyc();
        mem_ready = 1'b1;
        cyc();
        clr_in();
        cyc();

        // Saturate the stall counter with back-to-back load-use.
        ex_memRead = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
        repeat (SMAX + 5) cyc();
        chk("stall_sat", 32'(stall_cnt), 32'(SMAX));
        clr_in();

        // Timeout into ERROR, then async reset out of it.
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (MT + 2) cyc();
        chk("timeout_state", 32'(state), 32'd3);
        chk("timeout_err", 32'(err), 32'd1);
        do_reset();
        clr_in();

        slow_mem = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ((m_st == 3 && $urandom_range(0, 3) == 0) ||
                $urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 49) == 0) slow_mem = ~slow_mem;
                id_rs          = 5'($urandom_range(0, 3));
                id_rt          = 5'($urandom_range(0, 3));
                id_usesRt      = 1'($urandom_range(0, 1));
                ex_memRead     = ($urandom_range(0, 2) == 0);
                ex_rt          = 5'($urandom_range(0, 3));
                ex_branchTaken = ($urandom_range(0, 5) == 0);
                ex_jump        = ($urandom_range(0, 9) == 0);
                mem_req        = ($urandom_range(0, 2) == 0) || slow_mem;
                mem_ready      = slow_mem ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 2) != 0);
                cyc();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline; drives load-enable and flush of PC, IF/ID, ID/EX, EX/MEM and MEM/WB buffers.
- Buffers carry no reset of their own; this block clears them after reset by flushing for a fixed number of cycles.
- At run time it detects load-use hazards, flushes wrong-path instructions on taken branch/jump, and stalls on the data-memory ready handshake with a timeout.

Parameters:
INIT_CYCLES, 2, cycles spent flushing all buffers after reset (>=1)
MEM_TIMEOUT, 16, max consecutive data-memory stall cycles before ERROR (>=2)
STALL_CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_usesRt  in  1  ID instruction reads rt as a source
ex_memRead  in  1  instruction in EX is a load
ex_rt  in  5  destination rt of instruction in EX
ex_branchTaken  in  1  EX resolved a taken branch
ex_jump  in  1  instruction in EX is a jump
mem_req  in  1  instruction in MEM accesses data memory
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads bubble (overrides en)
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX loads bubble
exmem_en  out  1  EX/MEM load enable
exmem_flush  out  1  EX/MEM loads bubble
memwb_flush  out  1  MEM/WB loads bubble
state  out  2  INIT=0, RUN=1, MEM_WAIT=2, ERROR=3
err  out  1  sticky memory-timeout flag
stall_cnt  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- One clock `clk`; reset `rst` is asynchronous and active-high.
- Registered: state, init counter, wait_cnt, err, stall_cnt.
- Buffer-control outputs are combinational from state and current inputs (Mealy), so a response takes effect on the same edge.
- Reset: state=INIT, counters=0, err=0, stall_cnt=0. While rst is high, outputs are the INIT values.
- Reset mid-operation aborts any state immediately.
- INIT: pc_en=0; all four flushes=1; ifid_en/idex_en/exmem_en=1. After exactly INIT_CYCLES rising edges, go to RUN.
- RUN defaults: all enables=1, all flushes=0.
- RUN priority, highest first:
  1. mem_req&!mem_ready: pc_en, ifid_en, idex_en, exmem_en=0; memwb_flush=1; wait_cnt<=1; next MEM_WAIT.
  2. ex_branchTaken|ex_jump: ifid_flush=1, idex_flush=1; pc_en=1 (PC takes target); stay RUN.
  3. Load-use: ex_memRead && ex_rt!=0 && (ex_rt==id_rs || (id_usesRt && ex_rt==id_rt)). Then pc_en=0, ifid_en=0, idex_flush=1; stay RUN. The bubble clears ex_memRead, so the stall is exactly 1 cycle.
- mem_req&mem_ready in RUN is a zero-wait access; no stall.
- MEM_WAIT, while mem_req&!mem_ready: same hold outputs as RUN item 1.
  - If wait_cnt==MEM_TIMEOUT-1: next ERROR, err<=1. Else wait_cnt++.
  - Total stall before ERROR = MEM_TIMEOUT cycles.
- MEM_WAIT release (mem_ready=1, or mem_req=0): all enables=1; branch and load-use rules evaluated exactly as in RUN; next RUN; wait_cnt<=0.
- ERROR: pc_en=0, all other enables=0, all flushes=0. Pipeline is frozen; only rst exits.
- stall_cnt increments on every cycle with pc_en=0 in RUN or MEM_WAIT. It does not count in INIT or ERROR. Saturates at 2^STALL_CNT_W-1.
- Simultaneous events:
  - Memory stall beats branch and load-use; EX inputs are held, so the branch is acted on at release.
  - Branch beats load-use; the dependent ID instruction is wrong-path and flushed.
  - ex_rt==0 never stalls.

Test Plan:
- Reset, INIT_CYCLES=2 -> state=0 and all flushes=1, pc_en=0 for exactly 2 edges; then state=1, all en=1, flushes=0.
- RUN, ex_memRead=1, ex_rt=5, id_rs=5; next cycle ex_memRead=0 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Repeat with ex_rt=0 -> no stall.
- ex_branchTaken=1 together with the load-use hit -> ifid_flush=idex_flush=1, pc_en=1, stall_cnt unchanged.
- mem_req=1, mem_ready=0 for 3 cycles, then 1 -> 3 hold cycles with memwb_flush=1, state=2; release cycle all en=1; state=1; stall_cnt+=3.
- MEM_TIMEOUT=4, mem_ready stuck 0 -> 4 stall cycles, then state=3, err=1, all en=0. Assert rst -> state=0, err=0 asynchronously, without waiting for a clock edge.
- Branch taken during MEM_WAIT (held 2 cycles) -> no flush until release cycle; flush asserted in release cycle only.
